// File: rtl/stream_arb_rr_if.sv
// Stream bundle for stream_arb_rr: NumIn requester streams in, one tagged stream out.
// The slave modport is the arbiter side; the master modport is the source/sink side.
interface stream_arb_rr_if #(
    parameter int unsigned NumIn    = 4,
    parameter int unsigned DataBits = 8,
    parameter int unsigned IdBits   = $clog2(NumIn)
);
    logic [NumIn-1:0]          in_valid;
    logic [NumIn-1:0]          in_ready;
    logic [NumIn*DataBits-1:0] in_data;
    logic [NumIn-1:0]          in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [DataBits-1:0]       out_data;
    logic                      out_last;
    logic [IdBits-1:0]         out_src;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/stream_arb_rr.sv
// Round-robin stream arbiter with a 2-entry registered output buffer tagging beats by source.
// Define STREAM_ARB_RR_PKT_LOCK_EN to hold each grant from a packet's first beat until in_last.
module stream_arb_rr #(
    parameter int unsigned NumIn    = 4,
    parameter int unsigned DataBits = 8,
    parameter int unsigned IdBits   = $clog2(NumIn)
) (
    input  logic           clk,
    input  logic           rst,
    stream_arb_rr_if.slave bus
);

`ifdef STREAM_ARB_RR_PKT_LOCK_EN
    typedef enum logic [0:0] {StIdle, StLocked} state_e;
    state_e            r_state, w_state_d;
    logic [IdBits-1:0] r_grant, w_grant_d;
`endif

    logic [IdBits-1:0]   r_rr_ptr, w_rr_ptr_d;
    logic [IdBits-1:0]   w_winner, w_src;
    logic                w_found, w_not_full, w_push, w_pop, w_push_last;
    logic [NumIn-1:0]    w_in_ready;
    logic [DataBits-1:0] w_push_data;

    logic [1:0]          r_count, w_count_d;
    logic                r_out_valid;
    logic [DataBits-1:0] r_data0, r_data1, w_data0_d, w_data1_d;
    logic                r_last0, r_last1, w_last0_d, w_last1_d;
    logic [IdBits-1:0]   r_src0, r_src1, w_src0_d, w_src1_d;

    assign w_not_full = (r_count < 2'd2);
    assign w_pop      = r_out_valid & bus.out_ready;

    // First valid requester strictly after rr_ptr, wrapping modulo NumIn.
    always_comb begin
        logic [IdBits-1:0] cand;
        cand     = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned k = 1; k <= NumIn; k++) begin
            cand = IdBits'((32'(r_rr_ptr) + k) % NumIn);
            if (!w_found && bus.in_valid[cand]) begin
                w_found  = 1'b1;
                w_winner = cand;
            end
        end
    end

    always_comb begin
        w_in_ready = '0;
        w_rr_ptr_d = r_rr_ptr;
        w_src      = w_winner;
`ifdef STREAM_ARB_RR_PKT_LOCK_EN
        w_state_d  = r_state;
        w_grant_d  = r_grant;
        if (r_state == StLocked) begin
            w_src               = r_grant;
            w_in_ready[r_grant] = w_not_full;
        end else begin
            w_in_ready[w_winner] = w_found & w_not_full;
        end
`else
        w_in_ready[w_winner] = w_found & w_not_full;
`endif
        if (rst) begin
            w_in_ready = '0;
        end
        w_push      = |(bus.in_valid & w_in_ready);
        w_push_last = bus.in_last[w_src];
        w_push_data = bus.in_data[w_src*DataBits +: DataBits];
        if (w_push) begin
`ifdef STREAM_ARB_RR_PKT_LOCK_EN
            if (r_state == StIdle) begin
                w_rr_ptr_d = w_winner;
                if (!w_push_last) begin
                    w_state_d = StLocked;
                    w_grant_d = w_winner;
                end
            end else if (w_push_last) begin
                w_state_d = StIdle;
            end
`else
            w_rr_ptr_d = w_winner;
`endif
        end
    end

    // Entry 0 is always the head, so outputs come straight from registers.
    always_comb begin
        w_count_d = r_count;
        w_data0_d = r_data0;
        w_last0_d = r_last0;
        w_src0_d  = r_src0;
        w_data1_d = r_data1;
        w_last1_d = r_last1;
        w_src1_d  = r_src1;
        case ({w_push, w_pop})
            2'b10: begin
                w_count_d = r_count + 2'd1;
                if (r_count == 2'd0) begin
                    w_data0_d = w_push_data;
                    w_last0_d = w_push_last;
                    w_src0_d  = w_src;
                end else begin
                    w_data1_d = w_push_data;
                    w_last1_d = w_push_last;
                    w_src1_d  = w_src;
                end
            end
            2'b01: begin
                w_count_d = r_count - 2'd1;
                w_data0_d = r_data1;
                w_last0_d = r_last1;
                w_src0_d  = r_src1;
            end
            2'b11: begin
                if (r_count == 2'd1) begin
                    w_data0_d = w_push_data;
                    w_last0_d = w_push_last;
                    w_src0_d  = w_src;
                end else begin
                    w_data0_d = r_data1;
                    w_last0_d = r_last1;
                    w_src0_d  = r_src1;
                    w_data1_d = w_push_data;
                    w_last1_d = w_push_last;
                    w_src1_d  = w_src;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= IdBits'(NumIn - 1);
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_data0     <= '0;
            r_last0     <= 1'b0;
            r_src0      <= '0;
            r_data1     <= '0;
            r_last1     <= 1'b0;
            r_src1      <= '0;
`ifdef STREAM_ARB_RR_PKT_LOCK_EN
            r_state     <= StIdle;
            r_grant     <= '0;
`endif
        end else begin
            r_rr_ptr    <= w_rr_ptr_d;
            r_count     <= w_count_d;
            r_out_valid <= (w_count_d != 2'd0);
            r_data0     <= w_data0_d;
            r_last0     <= w_last0_d;
            r_src0      <= w_src0_d;
            r_data1     <= w_data1_d;
            r_last1     <= w_last1_d;
            r_src1      <= w_src1_d;
`ifdef STREAM_ARB_RR_PKT_LOCK_EN
            r_state     <= w_state_d;
            r_grant     <= w_grant_d;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_data0;
    assign bus.out_last  = r_last0;
    assign bus.out_src   = r_src0;

endmodule
